// File: rtl/slow_clk_monitor.sv
// rtl/slow_clk_monitor.sv - slow clock receiver: synchronizer, edge pulses, half-period meter, loss detect
module slow_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 16384
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             clk_lost
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       half_q, half_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   valid_q, valid_d;
  logic                   lost_q, lost_d;
  state_t                 state_q, state_d;

  logic s, rise, fall, edge_seen;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], slow_clk};
    s         = sync_q[SYNC_STAGES-1];
    prev_d    = s;
    rise      = s & ~prev_q;
    fall      = ~s & prev_q;
    edge_seen = rise | fall;
    rise_d    = rise;
    fall_d    = fall;

    if (edge_seen)             cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;

    state_d = state_q;
    half_d  = half_q;
    valid_d = valid_q;
    lost_d  = lost_q;
    case (state_q)
      IDLE: begin
        if (edge_seen) begin
          state_d = ARMED;
          lost_d  = 1'b0;
        end
      end
      ARMED, LOCKED: begin
        // An edge landing on the timeout cycle is still a valid measurement.
        if (edge_seen) begin
          state_d = LOCKED;
          half_d  = cnt_q + 1'b1;
          valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          valid_d = 1'b0;
          lost_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      half_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      state_q <= state_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = half_q;
  assign period_valid = valid_q;
  assign clk_lost     = lost_q;

endmodule
